// File: rtl/port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : port_arbiter
//  Brief    : Round-robin arbiter granting one of NREQ requesters access to a
//             single output port, with a registered flit output stage.
//             Optional grant locking for multicast bursts is compiled in when
//             the macro PORT_ARB_LOCK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module port_arbiter #(
  parameter int NREQ     = 7,
  parameter int DATASIZE = 30,
  parameter int LOCK_MAX = 3,
  localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] data_in,
  input  logic [NREQ-1:0]          lock_in,
  input  logic                     downstream_full,
  output logic [NREQ-1:0]          ready_out,
  output logic [DATASIZE-1:0]      data_out,
  output logic                     valid_out,
  output logic [IDXW-1:0]          grant_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);
  localparam logic [IDXW:0]   NREQ_EXT = (IDXW + 1)'(NREQ);

  // Registered state
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATASIZE-1:0] data_q;
  logic                valid_q;
  logic [IDXW-1:0]     gidx_q;

  // Combinational arbitration results
  logic                win_found;
  logic [IDXW-1:0]     win_idx;
  logic                grant;
  logic [IDXW-1:0]     gnt_idx;
  logic [NREQ-1:0]     gnt_onehot;

  // Unpacked view of the flattened flit bus
  logic [DATASIZE-1:0] slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = data_in[gi*DATASIZE +: DATASIZE];
    end
  endgenerate

  function automatic logic [IDXW-1:0] inc_wrap(input logic [IDXW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First requesting index at or after rr_ptr, wrapping past NREQ-1 to 0
  always_comb begin
    logic [IDXW:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDXW + 1)'(k);
      if (sum >= NREQ_EXT) sum = sum - NREQ_EXT;
      if (!win_found && req[sum[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IDXW-1:0];
      end
    end
  end

`ifdef PORT_ARB_LOCK_EN
  localparam int CNTW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [CNTW-1:0] lock_cnt_q, lock_cnt_d;

  // Grant decision, lock entry/exit and pointer update
  always_comb begin
    grant      = 1'b0;
    gnt_idx    = win_idx;
    rr_ptr_d   = rr_ptr_q;
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (!downstream_full && win_found) begin
          grant = 1'b1;
          // A burst limited to one grant is simply an ordinary grant
          if (lock_in[win_idx] && (LOCK_MAX > 1)) begin
            state_d    = LOCKED;
            owner_d    = win_idx;
            lock_cnt_d = CNTW'(1);
          end else begin
            rr_ptr_d = inc_wrap(win_idx);
          end
        end
      end
      LOCKED: begin
        // Backpressure freezes the burst in place
        if (!downstream_full) begin
          if (req[owner_q] && lock_in[owner_q]) begin
            grant      = 1'b1;
            gnt_idx    = owner_q;
            lock_cnt_d = lock_cnt_q + 1'b1;
            if (lock_cnt_d == CNTW'(LOCK_MAX)) begin
              state_d    = UNLOCKED;
              rr_ptr_d   = inc_wrap(owner_q);
              lock_cnt_d = '0;
            end
          end else begin
            // Owner withdrew: release without granting this cycle
            state_d    = UNLOCKED;
            rr_ptr_d   = inc_wrap(owner_q);
            lock_cnt_d = '0;
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Lock state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock_in;
  assign unused_lock_in = ^lock_in;

  // Plain round-robin grant decision and pointer update
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = win_idx;
    rr_ptr_d = rr_ptr_q;
    if (!downstream_full && win_found) begin
      grant    = 1'b1;
      rr_ptr_d = inc_wrap(win_idx);
    end
  end
`endif

  // One-hot pop strobe, forced low while in reset
  always_comb begin
    gnt_onehot          = '0;
    gnt_onehot[gnt_idx] = grant & ~rst;
  end

  assign ready_out = gnt_onehot;

  // Pointer and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      gidx_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= grant;
      if (grant) begin
        data_q <= slice[gnt_idx];
        gidx_q <= gnt_idx;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_idx = gidx_q;

endmodule
`default_nettype wire

// File: tb/tb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_arbiter
//  Brief    : Scoreboard bench for port_arbiter; directed vectors push the
//             expected winner, a monitor pops and compares on valid_out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_port_arbiter;

  localparam int NREQ = 7;
  localparam int DW   = 30;
  localparam int IW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]   lock_in;
  logic              downstream_full;
  logic [NREQ-1:0]   ready_out;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic [IW-1:0]     grant_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  port_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .LOCK_MAX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .data_in         (data_in),
    .lock_in         (lock_in),
    .downstream_full (downstream_full),
    .ready_out       (ready_out),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .grant_idx       (grant_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(input int i);
    return DW'(32'h0A5C_0001 + i * 32'h0000_1111);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle; w is the expected winner, -1 for no grant
  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                     input logic f, input int w);
    @(negedge clk);
    req = r; lock_in = l; downstream_full = f;
    #1;
    chk("ready_out", 64'(ready_out), (w < 0) ? 64'd0 : (64'd1 << w));
    if (w >= 0) exp_q.push_back(w);
    @(posedge clk);
    #1;
    chk("valid_out", 64'(valid_out), (w >= 0) ? 64'd1 : 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; lock_in = '0; downstream_full = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_gidx",  64'(grant_idx), 64'd0);
    chk("rst_data",  64'(data_out),  64'd0);
    req = 7'h7F;
    #1;
    chk("rst_ready", 64'(ready_out), 64'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents a flit
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got grant_idx %0d, expected no output", grant_idx);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("grant_idx", 64'(grant_idx), 64'(e));
          chk("data_out",  64'(data_out),  64'(dval(e)));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; lock_in = '0; downstream_full = 1'b0;
    for (int i = 0; i < NREQ; i++) data_in[i*DW +: DW] = dval(i);
    do_reset();

    // Round robin over all requesters, wrapping back to 0
    for (int i = 0; i < 8; i++) cyc(7'h7F, 7'h00, 1'b0, i % 7);
    cyc(7'h00, 7'h00, 1'b0, -1);

    // Backpressure stall then ordered grants
    do_reset();
    repeat (3) cyc(7'b0000101, 7'h00, 1'b1, -1);
    cyc(7'b0000101, 7'h00, 1'b0, 0);
    cyc(7'b0000101, 7'h00, 1'b0, 2);
    cyc(7'h00, 7'h00, 1'b0, -1);

    // Wrap search from pointer 6
    do_reset();
    cyc(7'b0100000, 7'h00, 1'b0, 5);
    cyc(7'b0000011, 7'h00, 1'b0, 0);
    cyc(7'b0000011, 7'h00, 1'b0, 1);
    cyc(7'h00, 7'h00, 1'b0, -1);

    // Asynchronous reset between edges while a flit is valid
    do_reset();
    cyc(7'b0001000, 7'h00, 1'b0, 3);
    #2;
    chk("pre_rst_valid", 64'(valid_out), 64'd1);
    req = '0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(valid_out), 64'd0);
    chk("async_rst_gidx",  64'(grant_idx), 64'd0);
    chk("async_rst_data",  64'(data_out),  64'd0);
    rst = 1'b0;
    cyc(7'b0010001, 7'h00, 1'b0, 0);
    cyc(7'h00, 7'h00, 1'b0, -1);

`ifdef PORT_ARB_LOCK_EN
    // Locked burst with a stall inside, then release to round robin
    do_reset();
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'b0100010, 7'b0000010, 1'b1, -1);
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'b0100010, 7'b0000010, 1'b0, 5);
    cyc(7'h00, 7'h00, 1'b0, -1);
    cyc(7'b0100010, 7'h00, 1'b0, 1);
    cyc(7'h00, 7'h00, 1'b0, -1);

    // Early release when the owner drops its lock request
    do_reset();
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'b0100010, 7'h00, 1'b0, -1);
    cyc(7'b0100010, 7'h00, 1'b0, 5);
    cyc(7'h00, 7'h00, 1'b0, -1);
`else
    // lock_in has no effect: plain alternation
    do_reset();
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'b0100010, 7'b0000010, 1'b0, 5);
    cyc(7'b0100010, 7'b0000010, 1'b0, 1);
    cyc(7'h00, 7'h00, 1'b0, -1);
`endif

    repeat (2) @(posedge clk);
    #3;
    chk("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
